sw_debounce: RTL

//   Conditions raw board slide-switch/push-button inputs before they reach the

---
 rtl/sw_debounce.sv | 85 ++++++++
 1 files changed

// File: rtl/sw_debounce.sv
// Switch conditioner: per-channel 2-FF synchroniser, bounce filter,
// registered level and one-cycle rise/fall pulses.
module sw_debounce #(
    parameter int CHANNELS        = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] sw_raw,
    output logic [CHANNELS-1:0] sw_level,
    output logic [CHANNELS-1:0] sw_rise,
    output logic [CHANNELS-1:0] sw_fall
);

    if (DEBOUNCE_CYCLES < 2 || CHANNELS < 1) begin : g_bad_params
        $error("sw_debounce: need DEBOUNCE_CYCLES >= 2 and CHANNELS >= 1");
    end

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CHANNELS-1:0] sync_q1;
    logic [CHANNELS-1:0] sync_q2;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    state_t              state [CHANNELS];
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] rise_d;
    logic [CHANNELS-1:0] fall_d;

    // State is implied by the counter: zero means the input agrees with the level.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state[i]   = (cnt_q[i] == '0) ? STABLE : COUNT;
            cnt_d[i]   = '0;
            level_d[i] = sw_level[i];
            rise_d[i]  = 1'b0;
            fall_d[i]  = 1'b0;
            unique case (state[i])
                STABLE: begin
                    if (sync_q2[i] != sw_level[i])
                        cnt_d[i] = CNT_ONE;
                end
                COUNT: begin
                    if (sync_q2[i] == sw_level[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        level_d[i] = sync_q2[i];
                        rise_d[i]  = sync_q2[i];
                        fall_d[i]  = ~sync_q2[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1  <= '0;
            sync_q2  <= '0;
            sw_level <= '0;
            sw_rise  <= '0;
            sw_fall  <= '0;
            for (int i = 0; i < CHANNELS; i++)
                cnt_q[i] <= '0;
        end else begin
            sync_q1  <= sw_raw;
            sync_q2  <= sync_q1;
            sw_level <= level_d;
            sw_rise  <= rise_d;
            sw_fall  <= fall_d;
            for (int i = 0; i < CHANNELS; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

endmodule
